// File: rtl/spi_rx_multi.sv
// Multi-lane SPI receive shifter with held output word, consumer ack and sticky overrun.
// One to four lanes are sampled per sclk edge. Words are assembled MSB-first or LSB-first.
module spi_rx_multi #(
  parameter int MaxBitCount     = 32,
  parameter int MaxBitCountLog2 = 6,
  parameter int Lanes           = 1
) (
  input  logic                       sclk,
  input  logic                       reset,
  input  logic [Lanes-1:0]           miso,
  input  logic [MaxBitCountLog2-1:0] read_length,
  input  logic                       lsb_first,
  input  logic                       start,
  input  logic                       data_ack,
  output logic [MaxBitCount-1:0]     data,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int W         = MaxBitCountLog2;
  localparam int LaneShift = $clog2(Lanes);
  localparam logic [W-1:0] MaxLen = W'(MaxBitCount);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                 state;
  logic [MaxBitCount-1:0] sreg;
  logic [MaxBitCount-1:0] beat;
  logic [MaxBitCount-1:0] nxt;
  logic [MaxBitCount-1:0] word;
  logic [W-1:0]           cnt;
  logic [W-1:0]           beats_r;
  logic [W-1:0]           beats_in;
  logic [W-1:0]           len_clip;
  logic [W-1:0]           pos;
  logic                   lsb_r;
  logic                   accept;
  logic                   done;

  // Length is clipped, then floored to whole beats by the shift.
  always_comb begin
    len_clip = (read_length > MaxLen) ? MaxLen : read_length;
    beats_in = len_clip >> LaneShift;
    beat     = MaxBitCount'(miso);
    pos      = cnt << LaneShift;
    nxt      = lsb_r ? (sreg | (beat << pos))
                     : ((sreg << Lanes) | beat);
    accept   = (state == IDLE) && start && (beats_in != '0);
    done     = (accept && (beats_in == W'(1)))
             || ((state == SHIFT) && (cnt == beats_r - W'(1)));
    word     = (state == IDLE) ? beat : nxt;
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      beats_r    <= '0;
      lsb_r      <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            lsb_r   <= lsb_first;
            beats_r <= beats_in;
            sreg    <= beat;
            if (done) begin
              cnt <= '0;
            end else begin
              cnt   <= W'(1);
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sreg <= nxt;
          cnt  <= cnt + W'(1);
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A finished word only replaces data if the old word is gone or leaving.
      if (done) begin
        if (!data_valid || data_ack) begin
          data       <= word;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_multi.sv
// Scoreboard bench for spi_rx_multi: one Lanes=1 and one Lanes=4 instance.
// Expected words are computed from beat values and queued; a monitor checks them.
module tb_spi_rx_multi;

  logic             sclk = 1'b0;
  logic             reset;
  logic [3:0]       mi;
  logic [5:0]       rl;
  logic             lsbf;
  logic [1:0]       st;
  logic [1:0]       ack;
  logic [1:0][31:0] dout;
  logic [1:0]       vld;
  logic [1:0]       bsy;
  logic [1:0]       ovr;

  int total = 0;
  int bad   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] m_data[2];
  bit          m_vld[2];
  bit          m_ovr[2];
  logic [1:0]  pa;
  logic [1:0]  pv;

  always #5 sclk = ~sclk;

  spi_rx_multi #(
    .MaxBitCount(32), .MaxBitCountLog2(6), .Lanes(1)
  ) dut1 (
    .sclk(sclk), .reset(reset), .miso(mi[0]), .read_length(rl),
    .lsb_first(lsbf), .start(st[0]), .data_ack(ack[0]),
    .data(dout[0]), .data_valid(vld[0]), .busy(bsy[0]),
    .overrun(ovr[0])
  );

  spi_rx_multi #(
    .MaxBitCount(32), .MaxBitCountLog2(6), .Lanes(4)
  ) dut4 (
    .sclk(sclk), .reset(reset), .miso(mi), .read_length(rl),
    .lsb_first(lsbf), .start(st[1]), .data_ack(ack[1]),
    .data(dout[1]), .data_valid(vld[1]), .busy(bsy[1]),
    .overrun(ovr[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // A new word is presented when valid rises or is refreshed under ack.
  always @(posedge sclk) pa <= ack;

  always @(negedge sclk) begin
    logic [31:0] e;
    for (int u = 0; u < 2; u++) begin
      if (vld[u] === 1'b1 && (pv[u] !== 1'b1 || pa[u] === 1'b1)) begin
        if ((u == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected u%0d: got %h want none", u, dout[u]);
        end else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("mon_word_u%0d", u), dout[u], e);
        end
      end
    end
    pv = vld;
  end

  task automatic xfer(input int u, input int len, input bit lf,
                      input logic [31:0] raw, input bit ackl,
                      input bit spam);
    int lanes;
    int l;
    int b;
    logic [31:0] w;
    logic [31:0] msk;
    logic [31:0] bt;
    lanes = (u != 0) ? 4 : 1;
    l = (len > 32) ? 32 : len;
    l = l - (l % lanes);
    b = l / lanes;
    msk = (32'd1 << lanes) - 32'd1;
    w = '0;
    for (int k = 0; k < b; k++) begin
      bt = (raw >> (k * lanes)) & msk;
      if (lf) w = w + (bt << (k * lanes));
      else    w = w + (bt << ((b - 1 - k) * lanes));
    end
    if (b == 0) begin
      rl = 6'(len);
      lsbf = lf;
      mi = raw[3:0];
      st[u] = 1'b1;
      @(negedge sclk);
      st[u] = 1'b0;
      chk("zero_busy", 32'(bsy[u]), 32'd0);
      chk("zero_data", dout[u], m_data[u]);
      chk("zero_valid", 32'(vld[u]), 32'(m_vld[u]));
      chk("zero_ovr", 32'(ovr[u]), 32'(m_ovr[u]));
      return;
    end
    for (int k = 0; k < b; k++) begin
      mi = 4'((raw >> (k * lanes)) & msk);
      st[u] = 1'((k == 0) || spam);
      rl = (k == 0) ? 6'(len) : 6'($urandom);
      lsbf = (k == 0) ? lf : 1'($urandom);
      ack[u] = 1'((k == b - 1) && ackl);
      if (k == b - 1) begin
        if (!m_vld[u] || ackl) begin
          if (u == 0) q0.push_back(w);
          else        q1.push_back(w);
          m_vld[u] = 1'b1;
          m_data[u] = w;
        end else begin
          m_ovr[u] = 1'b1;
        end
      end
      @(negedge sclk);
      chk("busy", 32'(bsy[u]), 32'(k < b - 1));
    end
    st[u] = 1'b0;
    ack[u] = 1'b0;
    chk("end_data", dout[u], m_data[u]);
    chk("end_valid", 32'(vld[u]), 32'(m_vld[u]));
    chk("end_ovr", 32'(ovr[u]), 32'(m_ovr[u]));
  endtask

  task automatic do_ack(input int u);
    ack[u] = 1'b1;
    @(negedge sclk);
    ack[u] = 1'b0;
    m_vld[u] = 1'b0;
    chk("ack_valid", 32'(vld[u]), 32'd0);
    chk("ack_data", dout[u], m_data[u]);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    st = '0;
    ack = '0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_data", dout[u], 32'd0);
      chk("rst_valid", 32'(vld[u]), 32'd0);
      chk("rst_busy", 32'(bsy[u]), 32'd0);
      chk("rst_ovr", 32'(ovr[u]), 32'd0);
      m_data[u] = '0;
      m_vld[u] = 1'b0;
      m_ovr[u] = 1'b0;
    end
    @(negedge sclk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mi = '0;
    rl = '0;
    lsbf = 1'b0;
    st = '0;
    ack = '0;
    @(negedge sclk);
    do_reset();

    xfer(0, 8, 1'b0, 32'hA5, 1'b0, 1'b0);
    chk("msb_a5", dout[0], 32'h0000_00A5);
    chk("msb_a5_valid", 32'(vld[0]), 32'd1);
    do_ack(0);

    xfer(0, 1, 1'b0, 32'h1, 1'b0, 1'b0);
    chk("len1_data", dout[0], 32'h1);
    xfer(0, 0, 1'b0, 32'h1, 1'b0, 1'b0);
    chk("len0_data", dout[0], 32'h1);
    do_ack(0);

    xfer(0, 8, 1'b1, 32'h11, 1'b0, 1'b0);
    xfer(0, 8, 1'b1, 32'h22, 1'b0, 1'b0);
    chk("ovr_data", dout[0], 32'h11);
    chk("ovr_flag", 32'(ovr[0]), 32'd1);
    do_reset();
    xfer(0, 8, 1'b1, 32'h11, 1'b0, 1'b0);
    xfer(0, 8, 1'b1, 32'h22, 1'b1, 1'b0);
    chk("ack_repl_data", dout[0], 32'h22);
    chk("ack_repl_valid", 32'(vld[0]), 32'd1);
    chk("ack_repl_ovr", 32'(ovr[0]), 32'd0);

    xfer(1, 16, 1'b1, 32'h4321, 1'b0, 1'b0);
    chk("quad_lsb", dout[1], 32'h0000_4321);
    do_ack(1);
    xfer(1, 16, 1'b0, 32'h4321, 1'b0, 1'b0);
    chk("quad_msb", dout[1], 32'h0000_1234);
    do_ack(1);

    do_ack(0);
    xfer(0, 8, 1'b0, $urandom, 1'b1, 1'b1);
    xfer(0, 8, 1'b1, $urandom, 1'b1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      mi = 4'(k & 1);
      st[0] = 1'(k == 0);
      rl = 6'd8;
      lsbf = 1'b0;
      @(negedge sclk);
    end
    st[0] = 1'b0;
    do_reset();
    xfer(0, 8, 1'b1, 32'h3C, 1'b0, 1'b0);
    chk("post_rst_3c", dout[0], 32'h3C);

    repeat (80) begin
      int u;
      u = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) do_ack(u);
      xfer(u, int'($urandom_range(0, 40)), 1'($urandom), $urandom,
           1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    repeat (2) @(negedge sclk);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
